// File: rtl/div_unit_pkg.sv
// ============================================================================
// div_unit_pkg : shared state encoding for the multi-cycle divider
// Rev 1.0
// ============================================================================
`default_nettype none

package div_unit_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

endpackage

`default_nettype wire

// File: rtl/div_unit.sv
// ============================================================================
// div_unit : restoring radix-2 32/32 divider, result {remainder, quotient}
// Rev 1.0
// ============================================================================
`default_nettype none

module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  div_state_e           r_state;
  div_state_e           w_next_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]     r_rem;
  logic [WIDTH-1:0]     r_dvd;
  logic [WIDTH-1:0]     r_dvs;
  logic                 r_sign_dvd;
  logic                 r_sign_dvs;
  logic [2*WIDTH-1:0]   r_result;
  logic                 r_ready;

  logic                 w_accept;
  logic                 w_dvs_zero;
  logic                 w_last;
  logic                 w_neg_dvd;
  logic                 w_neg_dvs;
  logic [WIDTH:0]       w_rem_shift;
  logic [WIDTH:0]       w_diff;
  logic                 w_qbit;
  logic [WIDTH-1:0]     w_rem_next;
  logic [WIDTH-1:0]     w_quot_next;
  logic [WIDTH-1:0]     w_quot_fix;
  logic [WIDTH-1:0]     w_rem_fix;

  assign w_accept   = start_i & ~annul_i;
  assign w_dvs_zero = (opdata2_i == '0);
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_neg_dvd  = signed_div_i & opdata1_i[WIDTH-1];
  assign w_neg_dvs  = signed_div_i & opdata2_i[WIDTH-1];

  // One restoring step: the top dividend bit shifts into the partial remainder.
  assign w_rem_shift = {r_rem, r_dvd[WIDTH-1]};
  assign w_diff      = w_rem_shift - {1'b0, r_dvs};
  assign w_qbit      = ~w_diff[WIDTH];
  assign w_rem_next  = w_qbit ? w_diff[WIDTH-1:0] : w_rem_shift[WIDTH-1:0];
  assign w_quot_next = {r_dvd[WIDTH-2:0], w_qbit};

  // Sign bits are only ever set for signed operations, so unsigned passes through.
  assign w_quot_fix = (r_sign_dvd ^ r_sign_dvs) ? -w_quot_next : w_quot_next;
  assign w_rem_fix  = r_sign_dvd ? -w_rem_next : w_rem_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= DIV_FREE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      DIV_FREE: begin
        if (w_accept) begin
          w_next_state = w_dvs_zero ? DIV_BY_ZERO : DIV_ON;
        end
      end
      DIV_BY_ZERO: w_next_state = DIV_END;
      DIV_ON: begin
        if (annul_i) begin
          w_next_state = DIV_FREE;
        end else if (w_last) begin
          w_next_state = DIV_END;
        end
      end
      DIV_END: begin
        if (!start_i) begin
          w_next_state = DIV_FREE;
        end
      end
      default: w_next_state = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_rem      <= '0;
      r_dvd      <= '0;
      r_dvs      <= '0;
      r_sign_dvd <= 1'b0;
      r_sign_dvs <= 1'b0;
      r_result   <= '0;
      r_ready    <= 1'b0;
    end else begin
      case (r_state)
        DIV_FREE: begin
          r_result <= '0;
          r_ready  <= 1'b0;
          if (w_accept && !w_dvs_zero) begin
            r_dvd      <= w_neg_dvd ? -opdata1_i : opdata1_i;
            r_dvs      <= w_neg_dvs ? -opdata2_i : opdata2_i;
            r_sign_dvd <= w_neg_dvd;
            r_sign_dvs <= w_neg_dvs;
            r_rem      <= '0;
            r_cnt      <= '0;
          end
        end
        DIV_BY_ZERO: begin
          r_result <= '0;
          r_ready  <= 1'b1;
        end
        DIV_ON: begin
          if (annul_i) begin
            r_cnt <= '0;
          end else begin
            r_rem <= w_rem_next;
            r_dvd <= w_quot_next;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_result <= {w_rem_fix, w_quot_fix};
              r_ready  <= 1'b1;
            end
          end
        end
        DIV_END: begin
          if (!start_i) begin
            r_result <= '0;
            r_ready  <= 1'b0;
          end
        end
        default: begin
          r_result <= '0;
          r_ready  <= 1'b0;
        end
      endcase
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// ============================================================================
// tb_div_unit : scoreboard bench for div_unit against an arithmetic model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int checks = 0;
  int errors = 0;

  logic [63:0] sb_q[$];

  div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero, div-by-zero gives 0.
  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'h0) return 64'h0;
    sa = sgn ? longint'($signed(a)) : longint'({32'h0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'h0, b});
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Monitor: pop on each rising ready_o, then require a stable result while it stays high.
  logic        prev_ready = 1'b0;
  logic [63:0] held;
  always @(negedge clk) begin
    if (ready_o && !prev_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_result", result_o, 64'hx);
      end else begin
        check("result", result_o, sb_q.pop_front());
      end
      held = result_o;
    end else if (ready_o && prev_ready) begin
      check("result_stable", result_o, held);
    end
    prev_ready = ready_o;
  end

  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input bit rst_in_end);
    int lat;
    int exp_lat;
    exp_lat = (b == 32'h0) ? 1 : 32;
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    sb_q.push_back(model(sgn, a, b));
    @(posedge clk);
    #1;
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    signed_div_i = 1'($urandom_range(0, 1));
    lat = 0;
    while (!ready_o && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    if (rst_in_end) begin
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("async_rst_end_ready", {63'h0, ready_o}, 64'h0);
      check("async_rst_end_result", result_o, 64'h0);
      @(negedge clk);
      start_i = 1'b0;
      rst     = 1'b0;
    end else begin
      repeat (hold) @(negedge clk);
      @(negedge clk);
      start_i = 1'b0;
      @(posedge clk);
      #1;
      check("drop_ready", {63'h0, ready_o}, 64'h0);
      check("drop_result", result_o, 64'h0);
    end
  endtask

  initial begin
    int highs;
    logic [31:0] a, b;
    logic        s;
    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    #12;
    check("reset_ready", {63'h0, ready_o}, 64'h0);
    check("reset_result", result_o, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    run_op(1'b0, 32'd100, 32'd7, 0, 1'b0);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1, 1'b0);
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 0, 1'b0);
    run_op(1'b0, 32'd1234, 32'd0, 0, 1'b0);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(1'b0, 32'd5, 32'd9, 5, 1'b0);

    // Annul in the middle of the iterations: no result may appear.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    highs = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o) highs++;
    end
    check("annul_no_ready", 64'(highs), 64'h0);
    run_op(1'b0, 32'd9, 32'd3, 0, 1'b0);

    // Asynchronous reset between edges while iterating.
    @(negedge clk);
    opdata1_i = 32'd77;
    opdata2_i = 32'd5;
    start_i   = 1'b1;
    repeat (15) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_on_ready", {63'h0, ready_o}, 64'h0);
    check("async_rst_on_result", result_o, 64'h0);
    @(negedge clk);
    start_i = 1'b0;
    rst     = 1'b0;
    highs = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o) highs++;
    end
    check("rst_no_ready", 64'(highs), 64'h0);

    run_op(1'b1, 32'hFFFF_FF00, 32'd7, 0, 1'b1);

    for (int i = 0; i < 24; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'h0;
        1:       b = $urandom_range(1, 15);
        2:       b = a + 32'd1;
        3:       b = -($urandom_range(1, 1000));
        default: b = $urandom;
      endcase
      run_op(s, a, b, $urandom_range(0, 3), 1'b0);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
